// File: rtl/controller_poller_if.sv
// Pad-side signal bundle for one NES-style gamepad poller.
// master = the poller, slave = the pad / MMIO consumer.
interface controller_poller_if #(
  parameter int NUM_BITS = 8
);
  logic                ctrl_data;
  logic                ctrl_latch;
  logic                ctrl_clk;
  logic [NUM_BITS-1:0] buttons;
  logic                valid;
  logic                busy;

  modport master (
    input  ctrl_data,
    output ctrl_latch, ctrl_clk, buttons, valid, busy
  );

  modport slave (
    output ctrl_data,
    input  ctrl_latch, ctrl_clk, buttons, valid, busy
  );
endinterface

// File: rtl/controller_poller.sv
// Periodically latches an NES-style pad, shifts out its button bits and
// publishes them active-high with a one-cycle valid strobe.
module controller_poller #(
  parameter int HALF_CYCLES = 150,
  parameter int NUM_BITS    = 8,
  parameter int POLL_CYCLES = 416667
) (
  input  logic                   clk,
  input  logic                   reset,
  controller_poller_if.master    pad
);

  localparam int PHASE_W = $clog2(2 * HALF_CYCLES) > 0 ? $clog2(2 * HALF_CYCLES) : 1;
  localparam int TIMER_W = $clog2(POLL_CYCLES) > 0 ? $clog2(POLL_CYCLES) : 1;
  localparam int IDX_W   = $clog2(NUM_BITS) > 0 ? $clog2(NUM_BITS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [TIMER_W-1:0]  timer_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] buttons_q;
  logic [1:0]          sync_q;
  logic                latch_q, sclk_q, busy_q, valid_q;

  logic data_sync;
  logic timer_term;
  logic phase_last;

  assign data_sync  = sync_q[1];
  assign timer_term = (timer_q == TIMER_W'(POLL_CYCLES - 1));
  assign phase_last = (state_q == S_LATCH) ? (phase_q == PHASE_W'(2 * HALF_CYCLES - 1))
                                           : (phase_q == PHASE_W'(HALF_CYCLES - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE:  if (timer_term) state_d = S_LATCH;
      S_LATCH: if (phase_last) state_d = S_LOW;
      S_LOW: begin
        if (phase_last) begin
          // Pad data is active-low; store it as pressed = 1.
          shift_d[idx_q] = ~data_sync;
          state_d        = (idx_q == IDX_W'(NUM_BITS - 1)) ? S_DONE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_last) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOW;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_LATCH && state_q != S_LATCH) idx_d = '0;
    phase_d = (state_d != state_q) ? '0 : phase_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      timer_q <= '0;
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], pad.ctrl_data};
      timer_q <= timer_term ? '0 : timer_q + 1'b1;
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Outputs are registered from next-state so they line up with the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q   <= 1'b0;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      buttons_q <= '0;
    end else begin
      latch_q <= (state_d == S_LATCH);
      sclk_q  <= (state_d == S_HIGH);
      busy_q  <= (state_d != S_IDLE);
      valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) buttons_q <= shift_q;
    end
  end

  assign pad.ctrl_latch = latch_q;
  assign pad.ctrl_clk   = sclk_q;
  assign pad.busy       = busy_q;
  assign pad.valid      = valid_q;
  assign pad.buttons    = buttons_q;

endmodule

// File: tb/tb_controller_poller.sv
// Scoreboard bench: a shift-register pad model issues the expected button word at
// each latch; a negedge monitor checks it, plus poll timing, when valid fires.
module tb_controller_poller;

  localparam int H   = 4;
  localparam int NB  = 8;
  localparam int P   = 200;
  localparam int PF  = 60;
  localparam int LAT = 2*H + NB*H + (NB-1)*H + 1;        // 69
  // Short-period instance: poll ends before 2nd terminal count, so starts every 2*PF.
  localparam int FAST_PERIOD = 2 * PF;
  localparam int M_PAD = 0, M_HOLD1 = 1, M_HOLD0 = 2;
  localparam int GLITCH_BIT = 2;
  localparam int GLITCH_CYC = 2*H + 2*GLITCH_BIT*H + (H-1) - 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controller_poller_if #(.NUM_BITS(NB)) bus ();
  controller_poller_if #(.NUM_BITS(NB)) bus_f ();

  controller_poller #(.HALF_CYCLES(H), .NUM_BITS(NB), .POLL_CYCLES(P))
    dut (.clk(clk), .reset(reset), .pad(bus));
  controller_poller #(.HALF_CYCLES(H), .NUM_BITS(NB), .POLL_CYCLES(PF))
    dut_fast (.clk(clk), .reset(reset), .pad(bus_f));

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int mode = M_PAD;
  logic [7:0] pattern = 8'h81;
  bit glitch_en = 1'b0;
  logic [7:0] sb_q[$];
  int valid_count = 0, f_valid_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main pad: 4021-style shift register loaded while latch is high.
  logic [7:0] pad_reg = 8'hFF;
  int pad_idx = 0, pad_cyc = 0;
  logic pad_latch_prev = 1'b0, pad_clk_prev = 1'b0;
  initial begin
    bus.ctrl_data = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.ctrl_latch && !pad_latch_prev) begin
        pad_cyc = 0;
        case (mode)
          M_HOLD1: sb_q.push_back(8'h00);
          M_HOLD0: sb_q.push_back(8'hFF);
          default: sb_q.push_back(pattern);
        endcase
      end else pad_cyc++;
      if (bus.ctrl_latch) begin
        pad_reg = pattern;
        pad_idx = 0;
      end else if (bus.ctrl_clk && !pad_clk_prev) pad_idx++;
      pad_latch_prev = bus.ctrl_latch;
      pad_clk_prev   = bus.ctrl_clk;
      if (mode == M_HOLD1)      bus.ctrl_data = 1'b1;
      else if (mode == M_HOLD0) bus.ctrl_data = 1'b0;
      else if (glitch_en && pad_cyc == GLITCH_CYC) bus.ctrl_data = 1'b0;
      else                      bus.ctrl_data = (pad_idx < NB) ? ~pad_reg[pad_idx] : 1'b1;
    end
  end

  // Fast-instance pad with a fixed pressed pattern.
  logic [7:0] f_pat = 8'h3C;
  int f_idx = 0;
  logic f_clk_prev = 1'b0;
  initial begin
    bus_f.ctrl_data = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus_f.ctrl_latch) f_idx = 0;
      else if (bus_f.ctrl_clk && !f_clk_prev) f_idx++;
      f_clk_prev = bus_f.ctrl_clk;
      bus_f.ctrl_data = (f_idx < NB) ? ~f_pat[f_idx] : 1'b1;
    end
  end

  // Monitor
  logic m_latch_prev = 0, m_clk_prev = 0;
  logic [7:0] m_buttons_prev = 0;
  int t0 = -10000, latch_len = 0, clk_pulses = 0, clk_w = 0;
  int prev_valid_cyc = 0;
  bit have_prev_valid = 0;
  logic f_latch_prev = 0, f_busy_prev = 0;
  int f_t0 = -10000;
  bit f_have = 0;
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb_q.delete();
        have_prev_valid = 0;
        f_have = 0;
        t0 = -10000;
        f_t0 = -10000;
      end else begin
        if (bus.ctrl_latch && !m_latch_prev) begin
          t0 = cyc; latch_len = 0; clk_pulses = 0;
        end
        if (bus.ctrl_latch) latch_len++;
        if (!bus.ctrl_latch && m_latch_prev) check("latch_width", 32'(latch_len), 32'(2*H));
        if (bus.ctrl_clk && !m_clk_prev) begin clk_pulses++; clk_w = 0; end
        if (bus.ctrl_clk) clk_w++;
        if (!bus.ctrl_clk && m_clk_prev) check("clk_width", 32'(clk_w), 32'(H));
        if (bus.valid) begin
          valid_count++;
          if (sb_q.size() == 0) check("spurious_valid", 32'(bus.valid), 32'd0);
          else begin
            exp = sb_q.pop_front();
            check("buttons", 32'(bus.buttons), 32'(exp));
            check("valid_latency", 32'(cyc - t0), 32'(LAT));
            check("clk_pulses", 32'(clk_pulses), 32'(NB - 1));
          end
          if (have_prev_valid) check("valid_period", 32'(cyc - prev_valid_cyc), 32'(P));
          prev_valid_cyc = cyc;
          have_prev_valid = 1;
        end
        if (bus.buttons !== m_buttons_prev) check("buttons_change_with_valid", 32'(bus.valid), 32'd1);

        if (bus_f.ctrl_latch && !f_latch_prev) begin
          check("fast_busy_before_latch", 32'(f_busy_prev), 32'd0);
          if (f_have) check("fast_poll_period", 32'(cyc - f_t0), 32'(FAST_PERIOD));
          f_t0 = cyc;
          f_have = 1;
        end
        if (bus_f.valid) begin
          f_valid_count++;
          check("fast_buttons", 32'(bus_f.buttons), 32'(f_pat));
          check("fast_latency", 32'(cyc - f_t0), 32'(LAT));
        end
      end
      m_latch_prev   = bus.ctrl_latch;
      m_clk_prev     = bus.ctrl_clk;
      m_buttons_prev = bus.buttons;
      f_latch_prev   = bus_f.ctrl_latch;
      f_busy_prev    = bus_f.busy;
    end
  end

  task automatic wait_valids(input int n);
    int start  = valid_count;
    int budget = (n + 2) * P;
    while (valid_count < start + n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (valid_count < start + n) check("valid_timeout", 32'(valid_count - start), 32'(n));
  endtask

  // Called with reset released just after a posedge; counts edges to first latch.
  task automatic check_first_poll_start();
    int n = 0;
    while (n < P + 50) begin
      @(posedge clk); #1;
      n++;
      if (bus.ctrl_latch) break;
    end
    check("first_poll_start", 32'(n), 32'(P));
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_latch"},   32'(bus.ctrl_latch), 32'd0);
    check({tag, "_clk"},     32'(bus.ctrl_clk),   32'd0);
    check({tag, "_busy"},    32'(bus.busy),       32'd0);
    check({tag, "_valid"},   32'(bus.valid),      32'd0);
    check({tag, "_buttons"}, 32'(bus.buttons),    32'd0);
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_outputs_reset("reset");
    reset = 1'b0;
    check_first_poll_start();
    wait_valids(1);                       // A + Right -> 8'h81

    mode = M_HOLD1; wait_valids(2);       // disconnected pad
    mode = M_HOLD0; wait_valids(1);       // everything pressed
    mode = M_PAD; pattern = 8'h55; wait_valids(2);

    repeat (6) begin
      pattern = 8'($urandom);
      wait_valids(1);
    end

    pattern = 8'h81; glitch_en = 1'b1; wait_valids(1);
    glitch_en = 1'b0;

    // Reset in the middle of a poll.
    pattern = 8'($urandom);
    budget = 2 * P;
    while (budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (bus.ctrl_latch) break;
    end
    check("latch_before_reset_seen", 32'(bus.ctrl_latch), 32'd1);
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_outputs_reset("midpoll_reset");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    check_first_poll_start();
    wait_valids(1);

    check("fast_polls_seen", 32'(f_valid_count >= 3), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
